// File: rtl/led_fade_pwm_if.sv
// Pin-side bundle of the LED fade stage: chaser pattern in, PWM pins and frame marker out.
// The chaser (or a bench) holds the master side; led_fade_pwm holds the slave side.
interface led_fade_pwm_if #(
    parameter int N_LED = 11
);
    logic [N_LED-1:0] led_on;
    logic [N_LED-1:0] ledc;
    logic             frame_start;

    modport master (
        output led_on,
        input  ledc,
        input  frame_start
    );

    modport slave (
        input  led_on,
        output ledc,
        output frame_start
    );
endinterface

// File: rtl/led_fade_pwm.sv
// Per-channel fading PWM driver for the badge LED chaser: lit channels jump to full, unlit ones decay.
// Define LED_FADE_GAMMA_EN to load a square-law corrected duty instead of the linear brightness.
module led_fade_pwm #(
    parameter int N_LED     = 11,
    parameter int PWM_BITS  = 8,
    parameter int FADE_DIV  = 20000,
    parameter int FADE_STEP = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    led_fade_pwm_if.slave bus
);
    localparam int                  DIV_W    = $clog2(FADE_DIV);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);
    localparam logic [PWM_BITS-1:0] BRI_MAX  = '1;
    localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(FADE_STEP);

    logic [DIV_W-1:0]    fdiv;
    logic [PWM_BITS-1:0] pcnt;
    logic                fade_tick;
    logic                wrap;

    logic [PWM_BITS-1:0] bri    [N_LED];
    logic [PWM_BITS-1:0] duty   [N_LED];
    logic [PWM_BITS-1:0] shaped [N_LED];

    logic [N_LED-1:0]    ledc_q;
    logic                frame_q;

    assign fade_tick = (fdiv == DIV_LAST);
    assign wrap      = (pcnt == BRI_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fdiv <= '0;
            pcnt <= '0;
        end else begin
            fdiv <= fade_tick ? '0 : fdiv + 1'b1;
            pcnt <= pcnt + 1'b1;
        end
    end

`ifdef LED_FADE_GAMMA_EN
    // Square-law correction: keep the upper half of bri*bri.
    function automatic logic [PWM_BITS-1:0] shape(input logic [PWM_BITS-1:0] b);
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, b} * {{PWM_BITS{1'b0}}, b};
        return sq[2*PWM_BITS-1:PWM_BITS];
    endfunction
`else
    function automatic logic [PWM_BITS-1:0] shape(input logic [PWM_BITS-1:0] b);
        return b;
    endfunction
`endif

    always_comb begin
        for (int i = 0; i < N_LED; i++) begin
            shaped[i] = shape(bri[i]);
        end
    end

    // Duty is sampled at wrap from the pre-update brightness, so a coincident
    // fade tick only becomes visible one period later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_LED; i++) begin
                bri[i]  <= '0;
                duty[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_LED; i++) begin
                if (bus.led_on[i]) begin
                    bri[i] <= BRI_MAX;
                end else if (fade_tick) begin
                    bri[i] <= (bri[i] >= STEP) ? bri[i] - STEP : '0;
                end
                if (wrap) begin
                    duty[i] <= shaped[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ledc_q  <= '0;
            frame_q <= 1'b0;
        end else begin
            for (int i = 0; i < N_LED; i++) begin
                ledc_q[i] <= (duty[i] > pcnt);
            end
            frame_q <= (pcnt == '0);
        end
    end

    assign bus.ledc        = ledc_q;
    assign bus.frame_start = frame_q;
endmodule

// File: tb/tb_led_fade_pwm.sv
// Randomized and directed bench for led_fade_pwm against a cycle-indexed behavioural model.
module tb_led_fade_pwm;
    localparam int N     = 11;
    localparam int PB    = 8;
    localparam int MAXV  = 255;
    localparam int PER   = 256;
    localparam int FDIV  = 4;
    localparam int FSTEP = 64;

`ifdef LED_FADE_GAMMA_EN
    localparam int E255 = 254;
    localparam int E191 = 142;
    localparam int E127 = 63;
    localparam int E63  = 15;
`else
    localparam int E255 = 255;
    localparam int E191 = 191;
    localparam int E127 = 127;
    localparam int E63  = 63;
`endif

    logic clk;
    logic rst_n;

    led_fade_pwm_if #(.N_LED(N)) bus ();

    led_fade_pwm #(
        .N_LED(N), .PWM_BITS(PB), .FADE_DIV(FDIV), .FADE_STEP(FSTEP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;

    logic [N:0] exp_q[$];
    int m_k;
    int m_bri  [N];
    int m_duty [N];
    int bri3_hist[$];

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic int shape(input int b);
`ifdef LED_FADE_GAMMA_EN
        return (b * b) / 256;
`else
        return b;
`endif
    endfunction

    // Model: cycle k since reset release has pcnt = k mod 256 and a fade tick when k mod FDIV == FDIV-1.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_k = 0;
                for (int i = 0; i < N; i++) begin
                    m_bri[i]  = 0;
                    m_duty[i] = 0;
                end
                exp_q.delete();
            end else begin
                int p;
                bit tick;
                int prev3;
                logic [N:0] e;
                p     = m_k % PER;
                tick  = (m_k % FDIV) == FDIV - 1;
                prev3 = m_bri[3];
                for (int i = 0; i < N; i++) e[i] = (m_duty[i] > p);
                e[N] = (p == 0);
                exp_q.push_back(e);
                if (p == PER - 1)
                    for (int i = 0; i < N; i++) m_duty[i] = shape(m_bri[i]);
                for (int i = 0; i < N; i++) begin
                    if (bus.led_on[i]) m_bri[i] = MAXV;
                    else if (tick) m_bri[i] = (m_bri[i] - FSTEP < 0) ? 0 : m_bri[i] - FSTEP;
                end
                if (m_bri[3] != prev3) bri3_hist.push_back(m_bri[3]);
                m_k++;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_ledc", int'(bus.ledc), 0);
                check("reset_frame_start", int'(bus.frame_start), 0);
            end else if (exp_q.size() == 0) begin
                check("model_queue_empty", 1, 0);
            end else begin
                logic [N:0] e;
                e = exp_q.pop_front();
                check("ledc", int'(bus.ledc), int'(e[N-1:0]));
                check("frame_start", int'(bus.frame_start), int'(e[N]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [N-1:0] val);
        @(negedge clk);
        #1 bus.led_on = val;
    endtask

    task automatic wait_phase(input int ph, input logic [N-1:0] val);
        int n;
        n = 0;
        @(negedge clk);
        while ((m_k % PER) != ph && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) check("wait_phase_timeout", n, 0);
        #1 bus.led_on = val;
    endtask

    task automatic wait_fs(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.frame_start && n < 600) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 600);
        if (!ok) check("frame_start_timeout", n, 0);
    endtask

    task automatic measure(input int ch, output int cnt);
        bit ok;
        cnt = 0;
        wait_fs(ok);
        if (ok) begin
            cnt = int'(bus.ledc[ch]);
            repeat (PER - 1) begin
                @(negedge clk);
                cnt += int'(bus.ledc[ch]);
            end
        end
    endtask

    task automatic frame_gap(output int gap);
        bit ok;
        gap = 0;
        wait_fs(ok);
        if (ok) begin
            do begin
                @(negedge clk);
                gap++;
            end while (!bus.frame_start && gap < 600);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        int gap;
        logic [N-1:0] r;
        int phases[4] = '{254, 250, 246, 242};
        int expect_cnt[4];
        expect_cnt = '{E255, E191, E127, E63};

        rst_n = 1'b0;
        bus.led_on = '1;
        repeat (10) @(negedge clk);
        check("reset_hold_ledc", int'(bus.ledc), 0);
        #1 rst_n = 1'b1;
        bus.led_on = '0;

        frame_gap(gap);
        check("frame_period", gap, PER);

        drive(11'h001);
        measure(0, c);
        measure(0, c);
        check("full_on_ch0", c, 255);
        measure(1, c);
        check("full_on_ch1", c, 0);

        drive('0);
        repeat (40) @(negedge clk);
        bri3_hist.delete();
        drive(11'h008);
        drive('0);
        repeat (30) @(negedge clk);
        check("trail_len", bri3_hist.size(), 5);
        if (bri3_hist.size() == 5) begin
            check("trail_0", bri3_hist[0], 255);
            check("trail_1", bri3_hist[1], 191);
            check("trail_2", bri3_hist[2], 127);
            check("trail_3", bri3_hist[3], 63);
            check("trail_4", bri3_hist[4], 0);
        end

        // Phase 251 is a fade-tick cycle; the next wrap (255) is also a tick.
        wait_phase(251, 11'h020);
        drive('0);
        check("prio_bri5", m_bri[5], 255);
        measure(5, c);
        check("prio_count5", c, E255);

        for (int j = 0; j < 4; j++) begin
            wait_phase(phases[j], 11'h200);
            drive('0);
            measure(9, c);
            check($sformatf("duty_curve_%0d", j), c, expect_cnt[j]);
        end

        drive(11'h080);
        repeat (600) @(negedge clk);
        wait_phase(100, '0);
        wait_phase(201, '0);
        check("mid_period_hold", int'(bus.ledc[7]), 1);
        measure(7, c);
        check("mid_period_next", c, 0);

        repeat (3000) begin
            for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 15) == 0);
            drive(r);
        end

        drive('1);
        repeat (600) @(negedge clk);
        check("pre_reset_lit", int'(bus.ledc[2]) | int'(bus.ledc[4]), 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_ledc", int'(bus.ledc), 0);
        check("async_reset_fs", int'(bus.frame_start), 0);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("first_frame_after_reset", int'(bus.frame_start), 1);
        frame_gap(gap);
        check("frame_period_after_reset", gap, PER);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
